led_pio: RTL



---
 rtl/led_pio_if.sv | 22 ++
 rtl/led_pio.sv | 107 ++++++++++
 2 files changed

// File: rtl/led_pio_if.sv
// Avalon-MM s1 slave bus for the LED output PIO: word address, active-low
// write strobe, 32-bit write data and registered read data.
interface led_pio_if;
   logic [2:0]  address;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  write_n,
      input  writedata,
      output readdata
   );
endinterface

// File: rtl/led_pio.sv
// Avalon-MM output PIO driving board LEDs: DATA register with atomic set/clear,
// plus a per-bit blink engine included only when LED_PIO_BLINK_EN is defined.
module led_pio #(
   parameter int unsigned DATA_WIDTH   = 18,
   parameter int unsigned PERIOD_WIDTH = 24
) (
   input  logic                  clk,
   input  logic                  reset,
   led_pio_if.slave              s1,
   output logic [DATA_WIDTH-1:0] out_port
);

   logic                  wr;
   logic [DATA_WIDTH-1:0] wd;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [31:0]           rdata_d;
   logic                  unused_wd;

   assign wr        = ~s1.write_n;
   assign wd        = s1.writedata[DATA_WIDTH-1:0];
   assign unused_wd = ^s1.writedata;

   always_comb begin
      data_d = data_q;
      if (wr) begin
         case (s1.address)
            3'd0:    data_d = wd;
            3'd4:    data_d = data_q | wd;
            3'd5:    data_d = data_q & ~wd;
            default: data_d = data_q;
         endcase
      end
   end

`ifdef LED_PIO_BLINK_EN
   logic [DATA_WIDTH-1:0]   mask_q, mask_d;
   logic [PERIOD_WIDTH-1:0] period_q, period_d;
   logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
   logic                    phase_q, phase_d;

   // A period write restarts the blink cycle from phase 0 on the same edge.
   always_comb begin
      mask_d   = mask_q;
      period_d = period_q;
      cnt_d    = cnt_q;
      phase_d  = phase_q;
      if (wr && s1.address == 3'd1) begin
         mask_d = wd;
      end
      if (wr && s1.address == 3'd2) begin
         period_d = s1.writedata[PERIOD_WIDTH-1:0];
         cnt_d    = '0;
         phase_d  = 1'b0;
      end else if (period_q == '0) begin
         cnt_d   = '0;
         phase_d = 1'b0;
      end else if (cnt_q == period_q) begin
         cnt_d   = '0;
         phase_d = ~phase_q;
      end else begin
         cnt_d = cnt_q + PERIOD_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mask_q   <= '0;
         period_q <= '0;
         cnt_q    <= '0;
         phase_q  <= 1'b0;
      end else begin
         mask_q   <= mask_d;
         period_q <= period_d;
         cnt_q    <= cnt_d;
         phase_q  <= phase_d;
      end
   end

   assign out_port = data_q ^ (mask_q & {DATA_WIDTH{phase_q}});
`else
   assign out_port = data_q;
`endif

   always_comb begin
      rdata_d = '0;
      case (s1.address)
         3'd0:    rdata_d = 32'(data_q);
`ifdef LED_PIO_BLINK_EN
         3'd1:    rdata_d = 32'(mask_q);
         3'd2:    rdata_d = 32'(period_q);
         3'd3:    rdata_d = {31'b0, phase_q};
`endif
         default: rdata_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_q      <= '0;
         s1.readdata <= '0;
      end else begin
         data_q      <= data_d;
         s1.readdata <= rdata_d;
      end
   end

endmodule
